muldiv_sequencer: RTL

Sequences the iterative multiplier and divider on behalf of the main multicycle control FSM. It accepts a one-cycle start request for MULT or DIV, drives the operand-load, iterate and HI/LO write-back strobes, and counts the iterations. It reports completion or a divide-by-zero exception back to the main FSM. It sits between the main control unit and the mult/div/HI/LO datapath, so the main FSM needs only one wait state per operation.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module  : muldiv_pkg
// Brief   : Shared state encoding and op constants for the mult/div sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER_DEFAULT  = 32;
  localparam int CNT_W_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CALC   = 3'd2,
    ST_RESULT = 3'd3,
    ST_DZERO  = 3'd4
  } state_t;

endpackage : muldiv_pkg

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module  : muldiv_sequencer
// Brief   : Drives load/iterate/write-back strobes of the iterative mult/div
//           datapath and reports completion or divide-by-zero to the main FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int ITER  = ITER_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divZero,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic divzero_exc,
  output logic mloadab,
  output logic mult,
  output logic dloadab,
  output logic div,
  output logic muxhigh,
  output logic muxlow,
  output logic highwrite,
  output logic lowwrite
);

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(ITER - 1);

  state_t           r_state;
  logic             r_op;
  logic [CNT_W-1:0] r_cnt;

  // Counter is only meaningful in CALC; everywhere else it rests at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MULT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (start && !abort) begin
            r_op    <= op;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if ((r_op == OP_DIV) && divZero) begin
            r_state <= ST_DZERO;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_CALC;
            r_cnt   <= c_CNT_LOAD;
          end
        end
        ST_CALC: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == '0) begin
            r_state <= ST_RESULT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        ST_DZERO: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  logic w_is_load;
  logic w_is_calc;
  logic w_is_result;

  assign w_is_load   = (r_state == ST_LOAD);
  assign w_is_calc   = (r_state == ST_CALC);
  assign w_is_result = (r_state == ST_RESULT);

  assign busy        = (r_state != ST_IDLE);
  assign done        = w_is_result;
  assign divzero_exc = (r_state == ST_DZERO);
  assign mloadab     = w_is_load && (r_op == OP_MULT);
  assign dloadab     = w_is_load && (r_op == OP_DIV);
  assign mult        = w_is_calc && (r_op == OP_MULT);
  assign div         = w_is_calc && (r_op == OP_DIV);
  assign muxhigh     = w_is_result && r_op;
  assign muxlow      = w_is_result && r_op;
  assign highwrite   = w_is_result;
  assign lowwrite    = w_is_result;

endmodule : muldiv_sequencer

`default_nettype wire
